// File: rtl/firefly_pkg.sv
// Shared types and nominal 50 MHz timing constants for the firefly stages.
package firefly_pkg;

    localparam int unsigned SENTINEL_WIDTH_CYC = 15000;
    localparam int unsigned PULSE_TOL_CYC      = 1000;
    localparam int unsigned PULSE_MIN_CYC      = SENTINEL_WIDTH_CYC - PULSE_TOL_CYC;
    localparam int unsigned PULSE_MAX_CYC      = SENTINEL_WIDTH_CYC + PULSE_TOL_CYC;
    localparam int unsigned DELAY_CYC_NOM      = 25000;
    localparam int unsigned ON_CYC_NOM         = 10000;
    localparam int unsigned OFF_CYC_NOM        = 10000;
    localparam int unsigned FLASH_NUM_NOM      = 3;
    localparam int unsigned CNT_W_NOM          = 16;
    localparam int unsigned FLASH_CNT_W        = 4;
    localparam int unsigned STAT_W             = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEASURE   = 3'd1,
        ST_LOCKOUT   = 3'd2,
        ST_DELAY     = 3'd3,
        ST_FLASH_ON  = 3'd4,
        ST_FLASH_OFF = 3'd5
    } worker_state_e;

endpackage

// File: rtl/firefly_worker_if.sv
// Pulse-in / flash-out bundle between the sentinel side and the firefly worker.
interface firefly_worker_if;
    import firefly_pkg::*;

    logic              f1;
    logic              f2;
    logic              busy;
    logic              err;
    logic              done;
    logic [STAT_W-1:0] resp_cnt;
    logic [STAT_W-1:0] err_cnt;

    modport master (output f1, input f2, busy, err, done, resp_cnt, err_cnt);
    modport slave  (input f1, output f2, busy, err, done, resp_cnt, err_cnt);
endinterface

// File: rtl/firefly_sync.sv
// Two-flop synchroniser for an asynchronous pulse, plus a delay flop for edge strobes.
module firefly_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic f1_s,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    // Strobes decode registered bits only, so they are glitch-free.
    assign f1_s = sync_q;
    assign rise = sync_q & ~dly_q;
    assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/firefly_worker.sv
// Firefly worker: validates the sentinel pulse width and answers with a flash burst.
// Optional FIREFLY_WORKER_ERR_CNT_EN builds the rejected-pulse counter err_cnt.
module firefly_worker
    import firefly_pkg::*;
#(
    parameter int unsigned PULSE_MIN = PULSE_MIN_CYC,
    parameter int unsigned PULSE_MAX = PULSE_MAX_CYC,
    parameter int unsigned DELAY_CYC = DELAY_CYC_NOM,
    parameter int unsigned ON_CYC    = ON_CYC_NOM,
    parameter int unsigned OFF_CYC   = OFF_CYC_NOM,
    parameter int unsigned FLASH_NUM = FLASH_NUM_NOM,
    parameter int unsigned CNT_W     = CNT_W_NOM
) (
    input  logic             clk,
    input  logic             rst_n,
    firefly_worker_if.slave  bus
);

    logic f1_s;
    logic rise;
    logic fall;

    firefly_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.f1),
        .f1_s     (f1_s),
        .rise     (rise),
        .fall     (fall)
    );

    worker_state_e          state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [FLASH_CNT_W-1:0] flash_q, flash_nxt;
    logic [STAT_W-1:0]      resp_q, resp_nxt;
    logic                   f2_q, f2_nxt;
    logic                   busy_q, busy_nxt;
    logic                   err_q, err_nxt;
    logic                   done_q, done_nxt;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flash_q <= '0;
            resp_q  <= '0;
            f2_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            flash_q <= flash_nxt;
            resp_q  <= resp_nxt;
            f2_q    <= f2_nxt;
            busy_q  <= busy_nxt;
            err_q   <= err_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next state, shared counter and registered output values.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        flash_nxt = flash_q;
        resp_nxt  = resp_q;
        err_nxt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_nxt   = '0;
                flash_nxt = '0;
                if (rise) begin
                    state_nxt = ST_MEASURE;
                    cnt_nxt   = CNT_W'(1);
                end
            end

            ST_MEASURE: begin
                if (fall) begin
                    cnt_nxt = '0;
                    if (cnt_q >= CNT_W'(PULSE_MIN)) begin
                        state_nxt = ST_DELAY;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end
                end else if (f1_s) begin
                    // Reaching PULSE_MAX+1 with the input still high is an overlong pulse.
                    if (cnt_q == CNT_W'(PULSE_MAX)) begin
                        state_nxt = ST_LOCKOUT;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                if (!f1_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end

            ST_DELAY: begin
                if (cnt_q == CNT_W'(DELAY_CYC)) begin
                    state_nxt = ST_FLASH_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_FLASH_ON: begin
                if (cnt_q == CNT_W'(ON_CYC - 1)) begin
                    state_nxt = ST_FLASH_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_FLASH_OFF: begin
                if (cnt_q == CNT_W'(OFF_CYC - 1)) begin
                    cnt_nxt   = '0;
                    flash_nxt = flash_q + FLASH_CNT_W'(1);
                    if (flash_q == FLASH_CNT_W'(FLASH_NUM - 1)) begin
                        state_nxt = ST_IDLE;
                        resp_nxt  = resp_q + STAT_W'(1);
                    end else begin
                        state_nxt = ST_FLASH_ON;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                flash_nxt = '0;
            end
        endcase

        f2_nxt   = (state_nxt == ST_FLASH_ON);
        busy_nxt = (state_nxt != ST_IDLE);
        // done covers the final cycle of the last OFF phase.
        done_nxt = (state_nxt == ST_FLASH_OFF) &&
                   (cnt_nxt == CNT_W'(OFF_CYC - 1)) &&
                   (flash_nxt == FLASH_CNT_W'(FLASH_NUM - 1));
    end

`ifdef FIREFLY_WORKER_ERR_CNT_EN
    logic [STAT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_nxt) begin
            err_cnt_q <= err_cnt_q + STAT_W'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.f2       = f2_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.done     = done_q;
    assign bus.resp_cnt = resp_q;

endmodule
